// File: rtl/ram_burst_ctrl_if.sv
// ram_burst_ctrl_if
// Bundles the request, write-stream, read-stream and status signals of the
// burst RAM controller.
//   master : the client (frame assembler / bench); drives requests, write beats, rdReady
//   slave  : the controller; drives wrReady, read beats and status
// Signals:
//   chipSel, wriEn, outEn, start, startAddr, burstLen  request side
//   wrData, wrValid / wrReady                           write stream
//   rdData, rdValid / rdReady                           read stream
//   busy, done, err                                     status
interface ram_burst_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 5
) ();
    logic              chipSel;
    logic              wriEn;
    logic              outEn;
    logic              start;
    logic [ADDR_W-1:0] startAddr;
    logic [LEN_W-1:0]  burstLen;
    logic [DATA_W-1:0] wrData;
    logic              wrValid;
    logic              wrReady;
    logic [DATA_W-1:0] rdData;
    logic              rdValid;
    logic              rdReady;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output chipSel, wriEn, outEn, start, startAddr, burstLen,
        output wrData, wrValid, rdReady,
        input  wrReady, rdData, rdValid, busy, done, err
    );

    modport slave (
        input  chipSel, wriEn, outEn, start, startAddr, burstLen,
        input  wrData, wrValid, rdReady,
        output wrReady, rdData, rdValid, busy, done, err
    );
endinterface

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
// Single-port synchronous RAM with an auto-incrementing burst controller.
// After reset every word is cleared to zero (one word per cycle), then write
// and read bursts of 1..2**LEN_W-1 beats are served over valid/ready streams.
// Addresses wrap from DEPTH-1 to 0. Dropping chipSel mid-burst aborts it.
// Ports:
//   clk  system clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  ram_burst_ctrl_if.slave: request, write stream, read stream, status
module ram_burst_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512,
    parameter int LEN_W  = 5
) (
    input  logic clk,
    input  logic rst,
    ram_burst_ctrl_if.slave bus
);
    // Index width of the storage array; DEPTH need not be a power of two.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    state_t state_r;
    state_t nextState_s;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addrNext_s;
    logic [LEN_W-1:0]  remain_r;
    logic [LEN_W-1:0]  remainNext_s;
    logic [ADDR_W-1:0] clrCnt_r;
    logic [ADDR_W-1:0] clrCntNext_s;
    logic [DATA_W-1:0] rdData_r;
    logic              rdValid_r;
    logic              rdValidNext_s;
    logic              rdLoad_s;
    logic              done_r;
    logic              doneNext_s;
    logic              err_r;
    logic              errNext_s;
    logic              memWe_s;
    logic [ADDR_W-1:0] memWAddr_s;
    logic [DATA_W-1:0] memWData_s;
    logic              request_s;
    logic              badReq_s;
    logic              issue_s;
    logic              consume_s;

    // Next sequential address, wrapping at the last implemented word.
    function automatic logic [ADDR_W-1:0] incAddr(input logic [ADDR_W-1:0] a);
        if (a == LAST_ADDR) begin
            incAddr = {ADDR_W{1'b0}};
        end else begin
            incAddr = a + ADDR_W'(1);
        end
    endfunction

    // Request decode and read-stream handshake terms.
    always_comb begin
        request_s = bus.start && bus.chipSel && (bus.wriEn || bus.outEn);
        badReq_s  = (bus.burstLen == {LEN_W{1'b0}}) ||
                    ({1'b0, bus.startAddr} >= DEPTH_EXT);
        // A new RAM read may be issued whenever the output register is empty
        // or is being emptied this cycle.
        issue_s   = bus.chipSel && (remain_r != {LEN_W{1'b0}}) &&
                    (!rdValid_r || bus.rdReady);
        consume_s = rdValid_r && bus.rdReady;
    end

    // Next-state and datapath control.
    always_comb begin
        nextState_s   = state_r;
        addrNext_s    = addr_r;
        remainNext_s  = remain_r;
        clrCntNext_s  = clrCnt_r;
        rdValidNext_s = rdValid_r;
        rdLoad_s      = 1'b0;
        doneNext_s    = 1'b0;
        errNext_s     = 1'b0;
        memWe_s       = 1'b0;
        memWAddr_s    = addr_r;
        memWData_s    = bus.wrData;

        case (state_r)
            CLEAR: begin
                memWe_s    = 1'b1;
                memWAddr_s = clrCnt_r;
                memWData_s = {DATA_W{1'b0}};
                if (clrCnt_r == LAST_ADDR) begin
                    clrCntNext_s = {ADDR_W{1'b0}};
                    nextState_s  = IDLE;
                end else begin
                    clrCntNext_s = clrCnt_r + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (request_s) begin
                    if (badReq_s) begin
                        errNext_s = 1'b1;
                    end else begin
                        addrNext_s    = bus.startAddr;
                        remainNext_s  = bus.burstLen;
                        rdValidNext_s = 1'b0;
                        nextState_s   = bus.wriEn ? WRITE : READ;
                    end
                end else begin
                    nextState_s = IDLE;
                end
            end
            WRITE: begin
                if (!bus.chipSel) begin
                    errNext_s   = 1'b1;
                    nextState_s = IDLE;
                end else if (bus.wrValid) begin
                    memWe_s      = 1'b1;
                    addrNext_s   = incAddr(addr_r);
                    remainNext_s = remain_r - LEN_W'(1);
                    if (remain_r == LEN_W'(1)) begin
                        doneNext_s  = 1'b1;
                        nextState_s = IDLE;
                    end else begin
                        nextState_s = WRITE;
                    end
                end else begin
                    nextState_s = WRITE;
                end
            end
            READ: begin
                if (!bus.chipSel) begin
                    errNext_s     = 1'b1;
                    rdValidNext_s = 1'b0;
                    nextState_s   = IDLE;
                end else if (issue_s) begin
                    rdLoad_s      = 1'b1;
                    rdValidNext_s = 1'b1;
                    addrNext_s    = incAddr(addr_r);
                    remainNext_s  = remain_r - LEN_W'(1);
                end else if (consume_s) begin
                    // Last beat leaves the register with nothing left to issue.
                    rdValidNext_s = 1'b0;
                    if (remain_r == {LEN_W{1'b0}}) begin
                        doneNext_s  = 1'b1;
                        nextState_s = IDLE;
                    end else begin
                        nextState_s = READ;
                    end
                end else begin
                    nextState_s = READ;
                end
            end
            default: begin
                rdValidNext_s = 1'b0;
                nextState_s   = CLEAR;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= CLEAR;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r    <= {ADDR_W{1'b0}};
            remain_r  <= {LEN_W{1'b0}};
            clrCnt_r  <= {ADDR_W{1'b0}};
            rdData_r  <= {DATA_W{1'b0}};
            rdValid_r <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            addr_r    <= addrNext_s;
            remain_r  <= remainNext_s;
            clrCnt_r  <= clrCntNext_s;
            rdValid_r <= rdValidNext_s;
            done_r    <= doneNext_s;
            err_r     <= errNext_s;
            if (rdLoad_s) begin
                rdData_r <= mem[addr_r[IDX_W-1:0]];
            end
        end
    end

    // Storage array write port (no reset; contents are cleared by CLEAR).
    always_ff @(posedge clk) begin
        if (memWe_s) begin
            mem[memWAddr_s[IDX_W-1:0]] <= memWData_s;
        end
    end

    assign bus.wrReady = (state_r == WRITE);
    assign bus.busy    = (state_r != IDLE);
    assign bus.rdData  = rdData_r;
    assign bus.rdValid = rdValid_r;
    assign bus.done    = done_r;
    assign bus.err     = err_r;
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl
// Directed bench for ram_burst_ctrl with DEPTH=512 and a 10-bit address so
// that out-of-range start addresses can be presented. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_ram_burst_ctrl;
    logic clk;
    logic rst;
    int   nVec;
    int   nMis;
    logic [7:0] model [512];

    ram_burst_ctrl_if #(.DATA_W(8), .ADDR_W(10), .LEN_W(5)) bus ();

    ram_burst_ctrl #(.DATA_W(8), .ADDR_W(10), .DEPTH(512), .LEN_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] nextAddr(input logic [9:0] a);
        return (a == 10'h1FF) ? 10'h000 : a + 10'd1;
    endfunction

    // Counts cycles of busy after reset release; CLEAR must take 512.
    task automatic waitClear(input string tag);
        int cnt;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        checkVal(tag, cnt, 32'd512);
        for (int i = 0; i < 512; i++) model[i] = 8'h00;
    endtask

    // mode 0: rdReady always 1; mode 1: rdReady pattern 1,0,0 repeating.
    task automatic readBurst(input logic [9:0] addr, input int len, input int mode);
        int beats, lastCyc;
        bit sawDone, stalled, rdy;
        logic [7:0] held;
        logic [9:0] a;
        a = addr; beats = 0; lastCyc = 0; sawDone = 1'b0; stalled = 1'b0; held = 8'h00;
        @(negedge clk);
        bus.start = 1'b1; bus.chipSel = 1'b1; bus.wriEn = 1'b0; bus.outEn = 1'b1;
        bus.startAddr = addr; bus.burstLen = 5'(len); bus.rdReady = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 400 && !sawDone; cyc++) begin
            if (stalled) begin
                checkVal("stall_valid", bus.rdValid, 32'd1);
                checkVal("stall_data", bus.rdData, held);
            end
            if (bus.done === 1'b1) begin
                sawDone = 1'b1;
                checkVal("rd_done_time", cyc, lastCyc + 1);
                checkVal("rd_done_valid", bus.rdValid, 32'd0);
                checkVal("rd_done_err", bus.err, 32'd0);
            end else begin
                rdy = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
                bus.rdReady = rdy;
                stalled = bus.rdValid && !rdy;
                held = bus.rdData;
                if (bus.rdValid && rdy) begin
                    checkVal("rd_data", bus.rdData, model[a[8:0]]);
                    if (mode == 0 && beats > 0) checkVal("rd_consecutive", cyc, lastCyc + 1);
                    a = nextAddr(a);
                    beats++;
                    lastCyc = cyc;
                end
                @(negedge clk);
            end
        end
        checkVal("rd_beats", beats, len);
        if (!sawDone) checkVal("rd_timeout", 32'd0, 32'd1);
        bus.rdReady = 1'b0; bus.outEn = 1'b0;
    endtask

    // Writes len beats base, base+1, ...; optional idle gap between beats;
    // chipSel is dropped before beat index abortAfter (if < len).
    task automatic writeBurst(input logic [9:0] addr, input int len, input logic [7:0] base,
                              input bit gap, input int abortAfter);
        logic [9:0] a;
        a = addr;
        @(negedge clk);
        bus.start = 1'b1; bus.chipSel = 1'b1; bus.wriEn = 1'b1; bus.outEn = 1'b0;
        bus.startAddr = addr; bus.burstLen = 5'(len); bus.wrValid = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        checkVal("wr_ready", bus.wrReady, 32'd1);
        checkVal("wr_busy", bus.busy, 32'd1);
        for (int i = 0; i < len; i++) begin
            if (i == abortAfter) begin
                bus.wrValid = 1'b0; bus.chipSel = 1'b0;
                @(negedge clk);
                checkVal("abort_err", bus.err, 32'd1);
                checkVal("abort_done", bus.done, 32'd0);
                checkVal("abort_busy", bus.busy, 32'd0);
                checkVal("abort_wrready", bus.wrReady, 32'd0);
                @(negedge clk);
                checkVal("abort_err_pulse", bus.err, 32'd0);
                bus.wriEn = 1'b0;
                return;
            end
            if (gap && i > 0) begin
                bus.wrValid = 1'b0;
                @(negedge clk);
            end
            bus.wrValid = 1'b1;
            bus.wrData = base + 8'(i);
            @(negedge clk);
            model[a[8:0]] = base + 8'(i);
            a = nextAddr(a);
            if (i < len - 1) checkVal("wr_nodone", bus.done, 32'd0);
        end
        bus.wrValid = 1'b0;
        checkVal("wr_done", bus.done, 32'd1);
        checkVal("wr_ready_off", bus.wrReady, 32'd0);
        checkVal("wr_err", bus.err, 32'd0);
        @(negedge clk);
        checkVal("wr_done_pulse", bus.done, 32'd0);
        bus.wriEn = 1'b0;
    endtask

    // Presents a single request in IDLE and checks err/busy response.
    task automatic request(input string tag, input logic cs, input logic [9:0] addr,
                           input int len, input logic expErr);
        @(negedge clk);
        bus.start = 1'b1; bus.chipSel = cs; bus.wriEn = 1'b0; bus.outEn = 1'b1;
        bus.startAddr = addr; bus.burstLen = 5'(len);
        @(negedge clk);
        bus.start = 1'b0; bus.outEn = 1'b0;
        checkVal(tag, bus.err, 32'(expErr));
        checkVal("req_busy", bus.busy, 32'd0);
        checkVal("req_done", bus.done, 32'd0);
        @(negedge clk);
        checkVal("req_err_clear", bus.err, 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_busy"}, bus.busy, 32'd1);
        checkVal({tag, "_wrready"}, bus.wrReady, 32'd0);
        checkVal({tag, "_rdvalid"}, bus.rdValid, 32'd0);
        checkVal({tag, "_rddata"}, bus.rdData, 32'd0);
        checkVal({tag, "_done"}, bus.done, 32'd0);
        checkVal({tag, "_err"}, bus.err, 32'd0);
    endtask

    initial begin
        nVec = 0; nMis = 0;
        rst = 1'b1;
        bus.chipSel = 1'b0; bus.wriEn = 1'b0; bus.outEn = 1'b0; bus.start = 1'b0;
        bus.startAddr = 10'h000; bus.burstLen = 5'd0; bus.wrData = 8'h00;
        bus.wrValid = 1'b0; bus.rdReady = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        waitClear("clear_cycles");

        // Cleared memory reads back zero at full throughput.
        readBurst(10'h000, 4, 0);

        // Gapped write across the wrap point, then read back A1..A4.
        writeBurst(10'h1FE, 4, 8'hA1, 1'b1, 99);
        readBurst(10'h1FE, 4, 0);
        checkVal("wrap_word0", model[0], 32'hA3);
        checkVal("wrap_word1", model[1], 32'hA4);

        // Stalled read stream.
        writeBurst(10'h040, 8, 8'h30, 1'b0, 99);
        readBurst(10'h040, 8, 1);

        // Rejected and ignored requests.
        request("err_len0", 1'b1, 10'h020, 0, 1'b1);
        request("err_addr", 1'b1, 10'h200, 4, 1'b1);
        request("ignored_cs0", 1'b0, 10'h020, 4, 1'b0);
        readBurst(10'h1FE, 4, 0);

        // Abort after two of six beats.
        writeBurst(10'h010, 6, 8'h51, 1'b0, 2);
        checkVal("abort_word2", model[10'h012], 32'h00);
        readBurst(10'h010, 6, 0);

        // Reset in the middle of a read burst.
        @(negedge clk);
        bus.start = 1'b1; bus.chipSel = 1'b1; bus.wriEn = 1'b0; bus.outEn = 1'b1;
        bus.startAddr = 10'h040; bus.burstLen = 5'd8; bus.rdReady = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("pre_rst_valid", bus.rdValid, 32'd1);
        #2 rst = 1'b1;
        #1 checkResetOutputs("midrst");
        @(negedge clk);
        bus.rdReady = 1'b0; bus.outEn = 1'b0;
        rst = 1'b0;
        waitClear("reclear_cycles");
        for (int b = 0; b < 32; b++) readBurst(10'(b * 16), 16, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Parametrised single-port synchronous RAM with a built-in burst access controller, the successor to the plain chipSel/wriEn/outEn RAM used in the CAN datapath. Replaces the bidirectional data bus with separate valid/ready write and read streams, adds auto-incrementing bursts with address wrap, and adds a post-reset clear sequence. Used as message/frame buffer storage behind the CAN frame assembler.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 9, address width in bits
DEPTH, 512, number of words; must satisfy DEPTH <= 2**ADDR_W, need not be a power of 2
LEN_W, 5, burst length field width; max burst = 2**LEN_W - 1 beats

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
chipSel  in  1  block select; must stay high for a whole burst
wriEn  in  1  sampled at start: 1 = write burst
outEn  in  1  sampled at start: 1 = read burst (ignored if wriEn=1)
start  in  1  burst request, accepted only in IDLE
startAddr  in  ADDR_W  first address of burst
burstLen  in  LEN_W  number of beats
wrData  in  DATA_W  write beat data
wrValid  in  1  write beat valid
wrReady  out  1  controller accepts write beat
rdData  out  DATA_W  read beat data
rdValid  out  1  read beat valid
rdReady  in  1  consumer accepts read beat
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse, burst completed
err  out  1  one-cycle pulse, request rejected or burst aborted

Behaviour:
- Reset values: wrReady=0, rdData=0, rdValid=0, done=0, err=0, busy=1; state=CLEAR, clear counter=0. rst mid-burst aborts it immediately; memory contents then undefined until CLEAR finishes.
- States: CLEAR, IDLE, WRITE, READ.
- CLEAR: writes 0 to address n on cycle n, n = 0..DEPTH-1 (DEPTH cycles total), then IDLE. start ignored, no err.
- IDLE: start && chipSel && (wriEn || outEn) -> check request:
  - burstLen==0 or startAddr>=DEPTH -> err pulse next cycle, stay IDLE.
  - else latch addr=startAddr, remaining=burstLen; wriEn=1 -> WRITE, else -> READ.
  - start with chipSel=0 or neither enable: ignored, no err.
- Address increment: addr+1; addr==DEPTH-1 wraps to 0.
- WRITE: wrReady=1 combinationally in WRITE. Beat = wrValid && wrReady: mem[addr]<=wrData, addr increments, remaining decrements. On last beat: done=1 next cycle, return IDLE, wrReady=0.
- READ: one-entry output register. Issue a RAM read when remaining>0 and (!rdValid || rdReady); data appears on rdData with rdValid=1 the next cycle (1-cycle latency). Full throughput with rdReady held high: one beat per cycle. rdData/rdValid held stable while rdValid && !rdReady. Beat consumed on rdValid && rdReady. done pulses the cycle after the last beat is consumed; rdValid=0 then; return IDLE.
- Abort: chipSel=0 in WRITE or READ -> next cycle IDLE, rdValid=0, wrReady=0, err=1 one cycle, no done; beats already written stay written.
- done and err never high in the same cycle. start while busy ignored.
- rdData retains last value after rdValid drops.

Test Plan:
- Reset then release: busy=1 for exactly 512 cycles after rst falls, then 0; read burst startAddr=0, burstLen=4, rdReady=1 -> four beats of 0x00 on consecutive cycles, done one cycle after the fourth.
- Write burst startAddr=0x1FE, burstLen=4, data A1,A2,A3,A4 (wrValid gapped one cycle between beats) -> writes only when wrValid; read back 0x1FE,0x1FF,0x000,0x001 = A1,A2,A3,A4.
- Read burst of 8 with rdReady toggling 1,0,0,1,... -> rdData/rdValid stable while stalled, 8 beats total in address order, no beat lost or duplicated.
- start with burstLen=0, then with startAddr=0x200 (DEPTH=512) -> err pulse each, busy stays 0, memory unchanged.
- chipSel dropped after 2 of 6 write beats -> err pulse, no done, IDLE; read back shows 2 new words, remaining 4 unchanged.
- rst asserted mid-read -> outputs at reset values immediately (rdValid=0, busy=1), CLEAR re-runs 512 cycles, all locations read 0.
